sc_stream_decoder: RTL

//  Stochastic-to-binary converter downstream of the scaling subtracter. Counts ones in its

---
 rtl/sc_stream_decoder_if.sv | 23 ++
 rtl/sc_stream_decoder.sv | 91 +++++++++
 2 files changed

// File: rtl/sc_stream_decoder_if.sv
// Handshake and result bundle between a stochastic bitstream source and sc_stream_decoder.
// The source drives start/bit_in/bit_en; the decoder returns window status and counts.
interface sc_stream_decoder_if #(
  parameter int WIDTH = 4
);
  logic                    start;
  logic                    bit_in;
  logic                    bit_en;
  logic                    busy;
  logic                    done;
  logic        [WIDTH:0]   result;
  logic signed [WIDTH+1:0] bipolar;

  modport master (
    output start, bit_in, bit_en,
    input  busy, done, result, bipolar
  );

  modport slave (
    input  start, bit_in, bit_en,
    output busy, done, result, bipolar
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts ones over a window of 2**WIDTH accepted samples
// and publishes the count as unipolar (0..2**WIDTH) and bipolar (2*count - 2**WIDTH) values.
module sc_stream_decoder #(
  parameter int WIDTH      = 4,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  sc_stream_decoder_if.slave   bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [WIDTH-1:0] CNT_LAST   = '1;
  localparam logic [WIDTH+1:0] FULL_SCALE = {2'b01, {WIDTH{1'b0}}};

  state_t                  state;
  logic        [WIDTH:0]   acc;
  logic        [WIDTH-1:0] cnt;
  logic        [WIDTH:0]   result;
  logic signed [WIDTH+1:0] bipolar;
  logic                    busy;
  logic                    done;
  logic        [WIDTH:0]   acc_next;

  function automatic logic [WIDTH:0] add_bit(input logic [WIDTH:0] sum, input logic b);
    return sum + {{WIDTH{1'b0}}, b};
  endfunction

  // Twice the count fits exactly in WIDTH+2 bits, so the subtraction cannot wrap.
  function automatic logic signed [WIDTH+1:0] to_bipolar(input logic [WIDTH:0] ones);
    logic [WIDTH+1:0] twice;
    twice = {ones, 1'b0};
    return signed'(twice - FULL_SCALE);
  endfunction

  assign acc_next = add_bit(acc, bus.bit_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      result  <= '0;
      bipolar <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start || CONTINUOUS) begin
            state <= ACCUM;
            busy  <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          if (bus.bit_en) begin
            if (cnt == CNT_LAST) begin
              // Final sample of the window is folded straight into the published result.
              result  <= acc_next;
              bipolar <= to_bipolar(acc_next);
              done    <= 1'b1;
              acc     <= '0;
              cnt     <= '0;
              if (!CONTINUOUS) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              acc <= acc_next;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.result  = result;
  assign bus.bipolar = bipolar;

endmodule
